// File: rtl/trapez_config_ctrl_pkg.sv
// Shared definitions for the trapezoidal shaper configuration controller:
// host register map, per-channel state encoding, the constant set carried
// per channel, reset defaults and the flush-length helper.
package trapez_config_ctrl_pkg;

    localparam int CONST_W         = 8;
    localparam int CNT_W           = 11;
    localparam int PIPELINE_STAGES = 8;
    localparam int PENDING_TIMEOUT = 1024;

    localparam logic [CONST_W-1:0] K_DEF    = 8'd25;
    localparam logic [CONST_W-1:0] L_DEF    = 8'd20;
    localparam logic [CONST_W-1:0] M_1_DEF  = 8'd3;
    localparam logic [CONST_W-1:0] M_2_DEF  = 8'd17;
    localparam logic [CONST_W-1:0] NORM_DEF = 8'd10;

    typedef enum logic [2:0] {
        ADDR_K      = 3'd0,
        ADDR_L      = 3'd1,
        ADDR_M_1    = 3'd2,
        ADDR_M_2    = 3'd3,
        ADDR_NORM   = 3'd4,
        ADDR_COMMIT = 3'd7
    } cfg_addr_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2
    } chan_state_t;

    typedef struct packed {
        logic [CONST_W-1:0] k;
        logic [CONST_W-1:0] l;
        logic [CONST_W-1:0] m_1;
        logic [CONST_W-1:0] m_2;
        logic [CONST_W-1:0] norm;
    } trapez_cfg_t;

    localparam trapez_cfg_t CFG_DEFAULTS = '{
        k: K_DEF, l: L_DEF, m_1: M_1_DEF, m_2: M_2_DEF, norm: NORM_DEF
    };

    // Counter load for a flush: the FLUSH state lasts K+L+PIPELINE_STAGES
    // cycles, counting down to zero inclusive.
    function automatic logic [CNT_W-1:0] flush_len(input trapez_cfg_t cfg);
        return CNT_W'(cfg.k) + CNT_W'(cfg.l) + CNT_W'(PIPELINE_STAGES - 1);
    endfunction

endpackage

// File: rtl/trapez_chan_cfg_fsm.sv
// One channel of the configuration controller: shadow and active constant
// registers plus the RUN / PENDING / FLUSH sequencer.
//   wr_en/wr_addr/wr_data : accepted shadow write (addr 0-4)
//   commit                : accepted, already validated commit
//   busy                  : shaper has a pulse in flight
//   active                : constants driven to the shaper
//   shadow_k/shadow_l     : shadow K and L for commit validation
//   pending               : channel is waiting to apply (blocks host)
//   shaper_clear          : 1-cycle clear, coincides with new constants
//   output_enable         : high while RUN or PENDING
//   commit_done           : 1-cycle pulse on return to RUN after a commit
module trapez_chan_cfg_fsm
    import trapez_config_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [CONST_W-1:0] wr_data,
    input  logic               commit,
    input  logic               busy,
    output trapez_cfg_t        active,
    output logic [CONST_W-1:0] shadow_k,
    output logic [CONST_W-1:0] shadow_l,
    output logic               pending,
    output logic               shaper_clear,
    output logic               output_enable,
    output logic               commit_done
);

    chan_state_t       state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              apply, flush_end;
    logic              oe_nx, done_nx;
    logic              committed;
    trapez_cfg_t       shadow;

    assign pending  = (state == ST_PENDING);
    assign shadow_k = shadow.k;
    assign shadow_l = shadow.l;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FLUSH;
            cnt   <= flush_len(CFG_DEFAULTS);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The counter doubles as the PENDING wait timer and the FLUSH length.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        apply     = 1'b0;
        flush_end = 1'b0;
        case (state)
            ST_RUN: begin
                if (commit) begin
                    state_nx = ST_PENDING;
                    cnt_nx   = '0;
                end
            end
            ST_PENDING: begin
                if (!busy || cnt == CNT_W'(PENDING_TIMEOUT - 1)) begin
                    apply    = 1'b1;
                    state_nx = ST_FLUSH;
                    cnt_nx   = flush_len(shadow);
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                // A new commit abandons the running flush.
                if (commit) begin
                    state_nx = ST_PENDING;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx  = ST_RUN;
                    flush_end = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_FLUSH;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        oe_nx   = (state_nx != ST_FLUSH);
        done_nx = flush_end && committed;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow        <= CFG_DEFAULTS;
            active        <= CFG_DEFAULTS;
            committed     <= 1'b0;
            shaper_clear  <= 1'b0;
            output_enable <= 1'b0;
            commit_done   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    ADDR_K:    shadow.k    <= wr_data;
                    ADDR_L:    shadow.l    <= wr_data;
                    ADDR_M_1:  shadow.m_1  <= wr_data;
                    ADDR_M_2:  shadow.m_2  <= wr_data;
                    ADDR_NORM: shadow.norm <= wr_data;
                    default:   ;
                endcase
            end
            if (apply) begin
                active <= shadow;
            end
            // Distinguishes a commit-triggered flush from the reset flush.
            if (apply) begin
                committed <= 1'b1;
            end else if (flush_end) begin
                committed <= 1'b0;
            end
            shaper_clear  <= apply;
            output_enable <= oe_nx;
            commit_done   <= done_nx;
        end
    end

endmodule

// File: rtl/trapez_config_ctrl.sv
// Configuration controller between the host register interface and the
// trapezoidal shaper channels. Decodes host requests, validates commits
// against the target channel's shadow K/L and fans out per-channel
// sequencers.
//   cfg_valid/cfg_ready   : host handshake; ready drops for a PENDING channel
//   cfg_channel/addr/data : target channel, register (0-4, 7=COMMIT), value
//   shaper_busy           : per-channel pulse-in-flight indication
//   k/l/m1/m2/norm_out    : active constants, channel c at [c*W +: W]
//   shaper_clear          : per-channel pipeline clear pulse
//   output_enable         : per-channel shaper output qualifier
//   commit_done           : per-channel commit completion pulse
//   cfg_error             : pulse after a rejected request
module trapez_config_ctrl
    import trapez_config_ctrl_pkg::*;
#(
    parameter int CHANNEL_SIZE   = 2,
    parameter int CONSTANT_SIZE  = CONST_W,
    parameter int SHIFT_REG_SIZE = 300
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [$clog2(CHANNEL_SIZE)-1:0]       cfg_channel,
    input  logic [2:0]                            cfg_addr,
    input  logic [CONSTANT_SIZE-1:0]              cfg_data,
    input  logic [CHANNEL_SIZE-1:0]               shaper_busy,
    output logic [CHANNEL_SIZE*CONSTANT_SIZE-1:0] k_out,
    output logic [CHANNEL_SIZE*CONSTANT_SIZE-1:0] l_out,
    output logic [CHANNEL_SIZE*CONSTANT_SIZE-1:0] m1_out,
    output logic [CHANNEL_SIZE*CONSTANT_SIZE-1:0] m2_out,
    output logic [CHANNEL_SIZE*CONSTANT_SIZE-1:0] norm_out,
    output logic [CHANNEL_SIZE-1:0]               shaper_clear,
    output logic [CHANNEL_SIZE-1:0]               output_enable,
    output logic [CHANNEL_SIZE-1:0]               commit_done,
    output logic                                  cfg_error
);

    logic [CHANNEL_SIZE-1:0] pending, wr_en, commit;
    logic [CONST_W-1:0]      shadow_k [CHANNEL_SIZE];
    logic [CONST_W-1:0]      shadow_l [CHANNEL_SIZE];
    logic                    accept, is_write, is_commit, is_reserved;
    logic [CONST_W:0]        kl_sum;
    logic                    shadow_ok;

    assign cfg_ready   = !pending[cfg_channel];
    assign accept      = cfg_valid && cfg_ready;
    assign is_write    = (cfg_addr <= ADDR_NORM);
    assign is_commit   = (cfg_addr == ADDR_COMMIT);
    assign is_reserved = !is_write && !is_commit;

    // One bit wider than the constants so K+L cannot wrap.
    assign kl_sum    = {1'b0, shadow_k[cfg_channel]} + {1'b0, shadow_l[cfg_channel]};
    assign shadow_ok = (shadow_k[cfg_channel] != '0) && (shadow_l[cfg_channel] != '0)
                       && (kl_sum <= (CONST_W+1)'(SHIFT_REG_SIZE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_error <= 1'b0;
        end else begin
            cfg_error <= accept && (is_reserved || (is_commit && !shadow_ok));
        end
    end

    for (genvar g = 0; g < CHANNEL_SIZE; g++) begin : g_chan
        trapez_cfg_t act;

        assign wr_en[g]  = accept && is_write && (int'(cfg_channel) == g);
        assign commit[g] = accept && is_commit && shadow_ok && (int'(cfg_channel) == g);

        trapez_chan_cfg_fsm u_fsm (
            .clk           (clk),
            .reset_n       (reset_n),
            .wr_en         (wr_en[g]),
            .wr_addr       (cfg_addr),
            .wr_data       (cfg_data),
            .commit        (commit[g]),
            .busy          (shaper_busy[g]),
            .active        (act),
            .shadow_k      (shadow_k[g]),
            .shadow_l      (shadow_l[g]),
            .pending       (pending[g]),
            .shaper_clear  (shaper_clear[g]),
            .output_enable (output_enable[g]),
            .commit_done   (commit_done[g])
        );

        assign k_out[g*CONSTANT_SIZE +: CONSTANT_SIZE]    = act.k;
        assign l_out[g*CONSTANT_SIZE +: CONSTANT_SIZE]    = act.l;
        assign m1_out[g*CONSTANT_SIZE +: CONSTANT_SIZE]   = act.m_1;
        assign m2_out[g*CONSTANT_SIZE +: CONSTANT_SIZE]   = act.m_2;
        assign norm_out[g*CONSTANT_SIZE +: CONSTANT_SIZE] = act.norm;
    end

endmodule

// File: tb/tb_trapez_config_ctrl.sv
module tb_trapez_config_ctrl;

    localparam logic [79:0] DEF_CFG = {16'h1919, 16'h1414, 16'h0303, 16'h1111, 16'h0a0a};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [0:0]  cfg_channel = '0;
    logic [2:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic [1:0]  shaper_busy = '0;
    logic [15:0] k_out, l_out, m1_out, m2_out, norm_out;
    logic [1:0]  shaper_clear, output_enable, commit_done;
    logic        cfg_error;

    int tests_run = 0;
    int fail_count = 0;

    // Reference model: per channel shadow/active constant sets, whether a
    // commit is waiting, how long it has waited, and how many output-disabled
    // cycles remain (including the current one).
    int  m_sh  [2][5];
    int  m_act [2][5];
    bit  m_wait [2];
    int  m_waited [2];
    int  m_flush [2];
    bit  m_after [2];
    logic [1:0] exp_clear, exp_done;
    logic       exp_err;

    trapez_config_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_channel   (cfg_channel),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .shaper_busy   (shaper_busy),
        .k_out         (k_out),
        .l_out         (l_out),
        .m1_out        (m1_out),
        .m2_out        (m2_out),
        .norm_out      (norm_out),
        .shaper_clear  (shaper_clear),
        .output_enable (output_enable),
        .commit_done   (commit_done),
        .cfg_error     (cfg_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_sh[c]     = '{25, 20, 3, 17, 10};
            m_act[c]    = '{25, 20, 3, 17, 10};
            m_wait[c]   = 1'b0;
            m_waited[c] = 0;
            m_flush[c]  = 25 + 20 + 8;
            m_after[c]  = 1'b0;
        end
        exp_clear = '0;
        exp_done  = '0;
        exp_err   = 1'b0;
    endfunction

    function automatic void model_edge();
        int  ch = int'(cfg_channel);
        int  a  = int'(cfg_addr);
        bit  acc, ok;
        int  commit_ch = -1;
        acc = cfg_valid && !m_wait[ch];
        ok  = (m_sh[ch][0] != 0) && (m_sh[ch][1] != 0) && (m_sh[ch][0] + m_sh[ch][1] <= 300);
        exp_clear = '0;
        exp_done  = '0;
        exp_err   = acc && (a == 5 || a == 6 || (a == 7 && !ok));
        if (acc && a == 7 && ok) commit_ch = ch;
        for (int c = 0; c < 2; c++) begin
            if (m_wait[c]) begin
                if (!shaper_busy[c] || m_waited[c] == 1023) begin
                    m_act[c]     = m_sh[c];
                    exp_clear[c] = 1'b1;
                    m_wait[c]    = 1'b0;
                    m_flush[c]   = m_sh[c][0] + m_sh[c][1] + 8;
                    m_after[c]   = 1'b1;
                end else begin
                    m_waited[c]++;
                end
            end else if (c == commit_ch) begin
                m_wait[c]   = 1'b1;
                m_waited[c] = 0;
            end else if (m_flush[c] > 0) begin
                m_flush[c]--;
                if (m_flush[c] == 0 && m_after[c]) begin
                    exp_done[c] = 1'b1;
                    m_after[c]  = 1'b0;
                end
            end
        end
        if (acc && a <= 4) m_sh[ch][a] = int'(cfg_data);
    endfunction

    function automatic logic [15:0] exp_cfg(input int idx);
        return {8'(m_act[1][idx]), 8'(m_act[0][idx])};
    endfunction

    function automatic logic [79:0] exp_all_cfg();
        return {exp_cfg(0), exp_cfg(1), exp_cfg(2), exp_cfg(3), exp_cfg(4)};
    endfunction

    function automatic logic [6:0] exp_ctrl();
        logic [1:0] oe;
        for (int c = 0; c < 2; c++) oe[c] = m_wait[c] || (m_flush[c] == 0);
        return {oe, exp_clear, exp_done, exp_err};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic host(input int ch, input int addr, input int data);
        cfg_valid   = 1'b1;
        cfg_channel = 1'(ch);
        cfg_addr    = 3'(addr);
        cfg_data    = 8'(data);
        step();
        cfg_valid = 1'b0;
    endtask

    // Releases reset and follows the power-up flush; entered with reset_n low.
    task automatic check_flush_after_reset();
        reset_n = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            tests_run++;
            if ({output_enable, shaper_clear, commit_done, cfg_error} !== exp_ctrl()) begin
                fail_count++;
                $display("FAIL flush_ctrl cycle %0d: got %b, expected %b", i,
                         {output_enable, shaper_clear, commit_done, cfg_error}, exp_ctrl());
            end
            tests_run++;
            if (commit_done !== 2'b00) begin
                fail_count++;
                $display("FAIL flush_no_done cycle %0d: got %b, expected 00", i, commit_done);
            end
            if (i == 52) begin
                tests_run++;
                if (output_enable !== 2'b00) begin
                    fail_count++;
                    $display("FAIL flush_oe_52: got %b, expected 00", output_enable);
                end
            end
            if (i == 53) begin
                tests_run++;
                if (output_enable !== 2'b11) begin
                    fail_count++;
                    $display("FAIL flush_oe_53: got %b, expected 11", output_enable);
                end
            end
        end
        tests_run++;
        if ({k_out, l_out, m1_out, m2_out, norm_out} !== DEF_CFG) begin
            fail_count++;
            $display("FAIL flush_defaults: got %h, expected %h", {k_out, l_out, m1_out, m2_out, norm_out}, DEF_CFG);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        step();
        step();
        tests_run++;
        if ({output_enable, shaper_clear, commit_done, cfg_error} !== 7'b0) begin
            fail_count++;
            $display("FAIL reset_ctrl: got %b, expected 0000000", {output_enable, shaper_clear, commit_done, cfg_error});
        end
        tests_run++;
        if ({k_out, l_out, m1_out, m2_out, norm_out} !== DEF_CFG) begin
            fail_count++;
            $display("FAIL reset_cfg: got %h, expected %h", {k_out, l_out, m1_out, m2_out, norm_out}, DEF_CFG);
        end
        check_flush_after_reset();
    endtask

    task automatic test_commit_ch0();
        int low = 0, clr_at = -1, done_at = -1;
        shaper_busy = 2'b00;
        host(0, 0, 40);
        host(0, 1, 30);
        host(0, 7, 0);
        tests_run++;
        if (k_out[7:0] !== 8'd25 || output_enable[0] !== 1'b1) begin
            fail_count++;
            $display("FAIL commit_pending: got k=%0d oe=%b, expected k=25 oe=1", k_out[7:0], output_enable[0]);
        end
        for (int i = 1; i <= 200 && done_at < 0; i++) begin
            step();
            tests_run++;
            if ({output_enable, shaper_clear, commit_done, cfg_error, k_out, l_out, m1_out, m2_out, norm_out}
                !== {exp_ctrl(), exp_all_cfg()}) begin
                fail_count++;
                $display("FAIL commit_cycle %0d: got %h, expected %h", i,
                         {output_enable, shaper_clear, commit_done, cfg_error, k_out, l_out, m1_out, m2_out, norm_out},
                         {exp_ctrl(), exp_all_cfg()});
            end
            if (!output_enable[0]) low++;
            if (shaper_clear[0] && clr_at < 0) clr_at = i;
            if (commit_done[0]) done_at = i;
        end
        tests_run++;
        if (clr_at !== 1) begin
            fail_count++;
            $display("FAIL commit_clear_time: got %0d, expected 1", clr_at);
        end
        tests_run++;
        if (low !== 78 || done_at !== 79) begin
            fail_count++;
            $display("FAIL commit_flush_len: got low=%0d done=%0d, expected low=78 done=79", low, done_at);
        end
        tests_run++;
        if (k_out !== 16'h1928 || l_out !== 16'h141e) begin
            fail_count++;
            $display("FAIL commit_applied: got k=%h l=%h, expected k=1928 l=141e", k_out, l_out);
        end
    endtask

    task automatic test_busy_wait();
        int done_at = -1;
        shaper_busy = 2'b10;
        host(1, 7, 0);
        for (int i = 0; i < 200; i++) begin
            cfg_valid   = 1'b1;
            cfg_channel = 1'(i % 2);
            cfg_addr    = 3'($urandom_range(0, 4));
            cfg_data    = 8'($urandom_range(1, 120));
            #1;
            tests_run++;
            if (cfg_ready !== ((i % 2) == 0)) begin
                fail_count++;
                $display("FAIL busy_ready ch%0d: got %b, expected %b", i % 2, cfg_ready, (i % 2) == 0);
            end
            step();
            tests_run++;
            if ({output_enable, shaper_clear, commit_done, cfg_error} !== exp_ctrl()) begin
                fail_count++;
                $display("FAIL busy_hold cycle %0d: got %b, expected %b", i,
                         {output_enable, shaper_clear, commit_done, cfg_error}, exp_ctrl());
            end
        end
        cfg_valid   = 1'b0;
        shaper_busy = 2'b00;
        step();
        tests_run++;
        if (shaper_clear !== 2'b10 || output_enable !== 2'b01) begin
            fail_count++;
            $display("FAIL busy_apply: got clr=%b oe=%b, expected clr=10 oe=01", shaper_clear, output_enable);
        end
        for (int i = 1; i <= 100 && done_at < 0; i++) begin
            step();
            tests_run++;
            if ({output_enable, shaper_clear, commit_done, cfg_error, k_out, l_out, m1_out, m2_out, norm_out}
                !== {exp_ctrl(), exp_all_cfg()}) begin
                fail_count++;
                $display("FAIL busy_flush cycle %0d: got %h, expected %h", i,
                         {output_enable, shaper_clear, commit_done, cfg_error, k_out, l_out, m1_out, m2_out, norm_out},
                         {exp_ctrl(), exp_all_cfg()});
            end
            if (commit_done[1]) done_at = i;
        end
        tests_run++;
        if (done_at !== 53) begin
            fail_count++;
            $display("FAIL busy_done_time: got %0d, expected 53", done_at);
        end
    endtask

    task automatic test_timeout();
        int clr_at = -1, done_at = -1;
        shaper_busy = 2'b00;
        host(0, 0, 40);
        host(0, 1, 30);
        shaper_busy = 2'b01;
        host(0, 7, 0);
        for (int n = 1; n <= 1100 && clr_at < 0; n++) begin
            step();
            tests_run++;
            if ({output_enable, shaper_clear, commit_done, cfg_error} !== exp_ctrl()) begin
                fail_count++;
                $display("FAIL timeout_wait cycle %0d: got %b, expected %b", n,
                         {output_enable, shaper_clear, commit_done, cfg_error}, exp_ctrl());
            end
            if (shaper_clear[0]) clr_at = n;
        end
        tests_run++;
        if (clr_at !== 1024) begin
            fail_count++;
            $display("FAIL timeout_apply_time: got %0d, expected 1024", clr_at);
        end
        shaper_busy = 2'b00;
        for (int i = 1; i <= 100 && done_at < 0; i++) begin
            step();
            if (commit_done[0]) done_at = i;
        end
        tests_run++;
        if (done_at !== 78) begin
            fail_count++;
            $display("FAIL timeout_done_time: got %0d, expected 78", done_at);
        end
    endtask

    task automatic test_reject();
        int low = 0, done_at = -1;
        int kv [5] = '{200, 0, 200, 150, 0};
        int lv [5] = '{150, 20, 101, 150, 0};
        logic [79:0] cfg_before;
        shaper_busy = 2'b00;
        cfg_before = {k_out, l_out, m1_out, m2_out, norm_out};
        for (int t = 0; t < 3; t++) begin
            host(1, 0, kv[t]);
            host(1, 1, lv[t]);
            host(1, 7, 0);
            tests_run++;
            if (cfg_error !== 1'b1 || output_enable !== 2'b11 || commit_done !== 2'b00) begin
                fail_count++;
                $display("FAIL reject_commit K=%0d L=%0d: got err=%b oe=%b, expected err=1 oe=11",
                         kv[t], lv[t], cfg_error, output_enable);
            end
            step();
            tests_run++;
            if (cfg_error !== 1'b0 || {k_out, l_out, m1_out, m2_out, norm_out} !== cfg_before) begin
                fail_count++;
                $display("FAIL reject_after K=%0d: got err=%b cfg=%h, expected err=0 cfg=%h",
                         kv[t], cfg_error, {k_out, l_out, m1_out, m2_out, norm_out}, cfg_before);
            end
        end
        for (int a = 5; a <= 6; a++) begin
            host(1, a, 8'h55);
            tests_run++;
            if (cfg_error !== 1'b1 || {k_out, l_out, m1_out, m2_out, norm_out} !== cfg_before) begin
                fail_count++;
                $display("FAIL reserved_addr %0d: got err=%b, expected err=1 and no change", a, cfg_error);
            end
        end
        host(1, 0, kv[3]);
        host(1, 1, lv[3]);
        host(1, 7, 0);
        tests_run++;
        if (cfg_error !== 1'b0) begin
            fail_count++;
            $display("FAIL accept_sum300: got err=%b, expected 0", cfg_error);
        end
        for (int i = 1; i <= 400 && done_at < 0; i++) begin
            step();
            tests_run++;
            if ({output_enable, shaper_clear, commit_done, cfg_error, k_out, l_out, m1_out, m2_out, norm_out}
                !== {exp_ctrl(), exp_all_cfg()}) begin
                fail_count++;
                $display("FAIL sum300_cycle %0d: got %h, expected %h", i,
                         {output_enable, shaper_clear, commit_done, cfg_error, k_out, l_out, m1_out, m2_out, norm_out},
                         {exp_ctrl(), exp_all_cfg()});
            end
            if (!output_enable[1]) low++;
            if (commit_done[1]) done_at = i;
        end
        tests_run++;
        if (low !== 308 || k_out[15:8] !== 8'd150) begin
            fail_count++;
            $display("FAIL sum300_flush: got low=%0d k=%0d, expected low=308 k=150", low, k_out[15:8]);
        end
    endtask

    task automatic test_flush_commit_reset();
        int low = 0, done_at = -1;
        shaper_busy = 2'b00;
        host(0, 0, 30);
        host(0, 1, 30);
        host(0, 7, 0);
        repeat (10) step();
        tests_run++;
        if (output_enable[0] !== 1'b0 || k_out[7:0] !== 8'd30) begin
            fail_count++;
            $display("FAIL fc_flushing: got oe=%b k=%0d, expected oe=0 k=30", output_enable[0], k_out[7:0]);
        end
        shaper_busy = 2'b01;
        host(0, 4, 99);
        host(0, 7, 0);
        repeat (5) step();
        tests_run++;
        if ({output_enable, shaper_clear, commit_done, cfg_error} !== exp_ctrl() || output_enable[0] !== 1'b1) begin
            fail_count++;
            $display("FAIL fc_pending: got %b, expected %b with oe0=1",
                     {output_enable, shaper_clear, commit_done, cfg_error}, exp_ctrl());
        end
        shaper_busy = 2'b00;
        step();
        tests_run++;
        if (shaper_clear[0] !== 1'b1 || output_enable[0] !== 1'b0 || norm_out[7:0] !== 8'd99) begin
            fail_count++;
            $display("FAIL fc_reapply: got clr=%b oe=%b norm=%0d, expected clr=1 oe=0 norm=99",
                     shaper_clear[0], output_enable[0], norm_out[7:0]);
        end
        repeat (20) step();
        host(1, 0, 7);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({output_enable, shaper_clear, commit_done, cfg_error} !== 7'b0 ||
            {k_out, l_out, m1_out, m2_out, norm_out} !== DEF_CFG) begin
            fail_count++;
            $display("FAIL async_reset: got ctrl=%b cfg=%h, expected ctrl=0 cfg=%h",
                     {output_enable, shaper_clear, commit_done, cfg_error}, {k_out, l_out, m1_out, m2_out, norm_out}, DEF_CFG);
        end
        step();
        step();
        check_flush_after_reset();
        host(0, 7, 0);
        for (int i = 1; i <= 100 && done_at < 0; i++) begin
            step();
            if (!output_enable[0]) low++;
            if (commit_done[0]) done_at = i;
        end
        tests_run++;
        if (low !== 53 || k_out !== 16'h1919 || norm_out !== 16'h0a0a) begin
            fail_count++;
            $display("FAIL shadow_discarded: got low=%0d k=%h norm=%h, expected low=53 k=1919 norm=0a0a",
                     low, k_out, norm_out);
        end
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 1500; i++) begin
            shaper_busy = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_channel = 1'($urandom_range(0, 1));
            a           = int'($urandom_range(0, 7));
            cfg_addr    = 3'(a);
            cfg_data    = (a <= 1) ? 8'($urandom_range(0, 170)) : 8'($urandom);
            #1;
            tests_run++;
            if (cfg_ready !== !m_wait[int'(cfg_channel)]) begin
                fail_count++;
                $display("FAIL rand_ready cycle %0d: got %b, expected %b", i, cfg_ready, !m_wait[int'(cfg_channel)]);
            end
            step();
            tests_run++;
            if ({output_enable, shaper_clear, commit_done, cfg_error, k_out, l_out, m1_out, m2_out, norm_out}
                !== {exp_ctrl(), exp_all_cfg()}) begin
                fail_count++;
                $display("FAIL rand_cycle %0d: got %h, expected %h", i,
                         {output_enable, shaper_clear, commit_done, cfg_error, k_out, l_out, m1_out, m2_out, norm_out},
                         {exp_ctrl(), exp_all_cfg()});
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit_ch0();
        test_busy_wait();
        test_timeout();
        test_reject();
        test_flush_commit_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
